// File: rtl/mp3_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mp3_bus_arbiter
// Purpose  : Shares one VS1003 MP3 decoder SPI bus between three per-scene
//            BGM players (0 = start, 1 = play, 2 = end). On every scene change
//            the bus is idled, the decoder is hardware-reset, DREQ is awaited,
//            and only then is the new owner released from its own reset so
//            that it replays its decoder init sequence from a clean state.
//            Scene 3 means mute: no player owns the bus.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   mp3_clk_i      in   1  mp3 clock (1 MHz), sole clock
//   rst_ni         in   1  asynchronous active-low reset
//   scene_i        in   2  requested scene (asynchronous to mp3_clk_i)
//   src_rset_i     in   3  player i RSET on bit i
//   src_cs_i       in   3  player i CS on bit i
//   src_dcs_i      in   3  player i DCS on bit i
//   src_mosi_i     in   3  player i MOSI on bit i
//   src_sclk_i     in   3  player i SCLK on bit i
//   src_rst_o      out  3  active-high reset to player i
//   src_dreq_o     out  3  DREQ forwarded to the owning player only
//   DREQ_i         in   1  decoder data request (asynchronous)
//   RSET_o         out  1  decoder hardware reset pin (active low)
//   CS_o           out  1  decoder command chip select
//   DCS_o          out  1  decoder data chip select
//   MOSI_o         out  1  decoder serial data in
//   SCLK_o         out  1  decoder serial clock
//   owner_o        out  2  current bus owner, 3 = none
//   busy_o         out  1  switch sequence in progress
//   err_o          out  1  sticky DREQ timeout flag
// ============================================================================
module mp3_bus_arbiter #(
  parameter int GAP_CYCLES   = 16,
  parameter int RST_CYCLES   = 2000,
  parameter int DREQ_TIMEOUT = 65535
) (
  input  logic       mp3_clk_i,
  input  logic       rst_ni,
  input  logic [1:0] scene_i,
  input  logic [2:0] src_rset_i,
  input  logic [2:0] src_cs_i,
  input  logic [2:0] src_dcs_i,
  input  logic [2:0] src_mosi_i,
  input  logic [2:0] src_sclk_i,
  output logic [2:0] src_rst_o,
  output logic [2:0] src_dreq_o,
  input  logic       DREQ_i,
  output logic       RSET_o,
  output logic       CS_o,
  output logic       DCS_o,
  output logic       MOSI_o,
  output logic       SCLK_o,
  output logic [1:0] owner_o,
  output logic       busy_o,
  output logic       err_o
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int CNT_W = 17;

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_GAP   = 2'd1;
  localparam logic [1:0] ST_HWRST = 2'd2;
  localparam logic [1:0] ST_WAIT  = 2'd3;

  localparam logic [1:0] NO_OWNER = 2'd3;

  // Terminal counter values: a phase of N cycles ends when the counter,
  // which starts at 0 on phase entry, reaches N-1. Zero-length settings are
  // treated as one cycle so the phase always exists.
  localparam int GAP_LAST_I  = (GAP_CYCLES   > 1) ? GAP_CYCLES   - 1 : 0;
  localparam int RST_LAST_I  = (RST_CYCLES   > 1) ? RST_CYCLES   - 1 : 0;
  localparam int WAIT_LAST_I = (DREQ_TIMEOUT > 1) ? DREQ_TIMEOUT - 1 : 0;

  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_LAST_I);
  localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_LAST_I);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_LAST_I);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  // --------------------------------------------------------------------------
  // Helper: player reset mask that releases only the granted player.
  // --------------------------------------------------------------------------
  function automatic logic [2:0] grant_mask(input logic [1:0] who);
    logic [2:0] mask;
    case (who)
      2'd0:    mask = 3'b110;
      2'd1:    mask = 3'b101;
      2'd2:    mask = 3'b011;
      default: mask = 3'b111;
    endcase
    return mask;
  endfunction

  // --------------------------------------------------------------------------
  // Input synchronizers (scene bus and DREQ come from other domains)
  // --------------------------------------------------------------------------
  logic [1:0] scene_meta_q;
  logic [1:0] scene_s_q;
  logic       dreq_meta_q;
  logic       dreq_s_q;

  always_ff @(posedge mp3_clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      scene_meta_q <= 2'd0;
      scene_s_q    <= 2'd0;
      dreq_meta_q  <= 1'b0;
      dreq_s_q     <= 1'b0;
    end else begin
      scene_meta_q <= scene_i;
      scene_s_q    <= scene_meta_q;
      dreq_meta_q  <= DREQ_i;
      dreq_s_q     <= dreq_meta_q;
    end
  end

  // --------------------------------------------------------------------------
  // Switch sequencer state
  // --------------------------------------------------------------------------
  logic [1:0]       state_q,   state_d;
  logic [1:0]       target_q,  target_d;
  logic [1:0]       owner_q,   owner_d;
  logic [2:0]       src_rst_q, src_rst_d;
  logic             err_q,     err_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;

  logic [CNT_W-1:0] cnt_inc;
  logic             wait_timeout;

  // Saturating increment: the counter must never wrap back into range.
  assign cnt_inc      = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
  assign wait_timeout = (cnt_q >= WAIT_LAST);

  always_comb begin
    state_d   = state_q;
    target_d  = target_q;
    owner_d   = owner_q;
    src_rst_d = src_rst_q;
    err_d     = err_q;
    cnt_d     = cnt_inc;

    case (state_q)
      ST_RUN: begin
        cnt_d = '0;
        if (scene_s_q != owner_q) begin
          target_d  = scene_s_q;
          src_rst_d = 3'b111;
          owner_d   = NO_OWNER;
          state_d   = ST_GAP;
        end
      end

      // In the sequence states the target follows the live request every
      // cycle; decisions use scene_s_q, which is the value target takes on
      // this edge, so the grant always reflects the most recent request.
      ST_GAP: begin
        target_d = scene_s_q;
        if (cnt_q >= GAP_LAST) begin
          cnt_d = '0;
          if (scene_s_q == NO_OWNER) begin
            // Mute: nobody will own the bus, so the decoder reset is skipped.
            state_d = ST_RUN;
          end else begin
            state_d = ST_HWRST;
          end
        end
      end

      ST_HWRST: begin
        target_d = scene_s_q;
        if (cnt_q >= RST_LAST) begin
          cnt_d   = '0;
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        target_d = scene_s_q;
        if (dreq_s_q || wait_timeout) begin
          cnt_d     = '0;
          state_d   = ST_RUN;
          owner_d   = scene_s_q;
          src_rst_d = grant_mask(scene_s_q);
          // A late DREQ on the final cycle still counts as a clean exit.
          if (!dreq_s_q) begin
            err_d = 1'b1;
          end
        end
      end

      default: begin
        state_d   = ST_RUN;
        owner_d   = NO_OWNER;
        target_d  = NO_OWNER;
        src_rst_d = 3'b111;
        cnt_d     = '0;
      end
    endcase
  end

  always_ff @(posedge mp3_clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_RUN;
      target_q  <= NO_OWNER;
      owner_q   <= NO_OWNER;
      src_rst_q <= 3'b111;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      target_q  <= target_d;
      owner_q   <= owner_d;
      src_rst_q <= src_rst_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // Decoder pin mux
  // --------------------------------------------------------------------------
  // The mux select is taken from the next state, so the bus goes idle on the
  // very edge the switch is decided (no extra cycle of the old owner's SPI)
  // and all five pins share the same single register stage.
  logic rset_q, rset_d;
  logic cs_q,   cs_d;
  logic dcs_q,  dcs_d;
  logic mosi_q, mosi_d;
  logic sclk_q, sclk_d;

  always_comb begin
    rset_d = 1'b1;
    cs_d   = 1'b1;
    dcs_d  = 1'b1;
    mosi_d = 1'b0;
    sclk_d = 1'b0;

    if (state_d == ST_RUN) begin
      case (owner_d)
        2'd0: begin
          rset_d = src_rset_i[0];
          cs_d   = src_cs_i[0];
          dcs_d  = src_dcs_i[0];
          mosi_d = src_mosi_i[0];
          sclk_d = src_sclk_i[0];
        end
        2'd1: begin
          rset_d = src_rset_i[1];
          cs_d   = src_cs_i[1];
          dcs_d  = src_dcs_i[1];
          mosi_d = src_mosi_i[1];
          sclk_d = src_sclk_i[1];
        end
        2'd2: begin
          rset_d = src_rset_i[2];
          cs_d   = src_cs_i[2];
          dcs_d  = src_dcs_i[2];
          mosi_d = src_mosi_i[2];
          sclk_d = src_sclk_i[2];
        end
        default: begin
          rset_d = 1'b1;
        end
      endcase
    end else if (state_d == ST_HWRST) begin
      rset_d = 1'b0;
    end
  end

  always_ff @(posedge mp3_clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rset_q <= 1'b1;
      cs_q   <= 1'b1;
      dcs_q  <= 1'b1;
      mosi_q <= 1'b0;
      sclk_q <= 1'b0;
    end else begin
      rset_q <= rset_d;
      cs_q   <= cs_d;
      dcs_q  <= dcs_d;
      mosi_q <= mosi_d;
      sclk_q <= sclk_d;
    end
  end

  // --------------------------------------------------------------------------
  // DREQ fan-out: only the owner sees DREQ, and only while it holds the bus.
  // --------------------------------------------------------------------------
  logic [2:0] src_dreq_w;

  always_comb begin
    src_dreq_w = 3'b000;
    if ((state_q == ST_RUN) && dreq_s_q) begin
      case (owner_q)
        2'd0:    src_dreq_w = 3'b001;
        2'd1:    src_dreq_w = 3'b010;
        2'd2:    src_dreq_w = 3'b100;
        default: src_dreq_w = 3'b000;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign src_rst_o  = src_rst_q;
  assign src_dreq_o = src_dreq_w;
  assign RSET_o     = rset_q;
  assign CS_o       = cs_q;
  assign DCS_o      = dcs_q;
  assign MOSI_o     = mosi_q;
  assign SCLK_o     = sclk_q;
  assign owner_o    = owner_q;
  assign busy_o     = (state_q != ST_RUN);
  assign err_o      = err_q;

endmodule
`default_nettype wire
